// File: rtl/it2_inf_pkg.sv
// Shared types and helpers for the interval type-2 inference stage.
//   state_t           : rule-engine sequencer states
//   TNORM_MIN/PROD    : encodings of the t-norm select input
//   W_DEFAULT         : default membership grade width
//   rule_a_idx/_b_idx : map a rule number onto its (A set, B set) pair
package it2_inf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic TNORM_MIN  = 1'b0;
    localparam logic TNORM_PROD = 1'b1;

    localparam int W_DEFAULT = 8;

    // Rules are laid out row-major: A set is the row, B set the column.
    function automatic int rule_a_idx(input int r, input int n_b);
        return r / n_b;
    endfunction

    function automatic int rule_b_idx(input int r, input int n_b);
        return r % n_b;
    endfunction

endpackage

// File: rtl/it2_tnorm.sv
// Combinational t-norm of two membership grades.
//   mode : TNORM_MIN selects min(a, b), TNORM_PROD selects (a*b) >> W
//   a, b : W-bit grades
//   y    : W-bit result
// The product is truncated, so full scale times full scale lands one LSB
// short of full scale (255*255 -> 254 for W=8).
module it2_tnorm
    import it2_inf_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [2*W-1:0] prod;

    always_comb begin
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (mode == TNORM_PROD) begin
            y = W'(prod >> W);
        end else begin
            y = (a < b) ? a : b;
        end
    end

endmodule

// File: rtl/it2_rule_engine.sv
// Sequential interval type-2 rule evaluation: one rule per clock.
//   clk, rst            : clock, asynchronous active-low reset
//   start, mode         : evaluation request and t-norm select (latched together)
//   fou_a_up/low        : upper/lower grades of input A, set i at [i*W +: W]
//   fou_b_up/low        : upper/lower grades of input B
//   cfg_we/addr/data    : rule table write, data = {enable, consequent}
//   busy, done          : evaluation in progress / one-cycle result strobe
//   out_up/out_low      : aggregated firing interval per consequent
//
// state  | meaning
// IDLE   | waiting for start; rule table writable
// RUN    | evaluating rule rule_q, aggregating into the accumulators
// FINISH | publishing the accumulators, pulsing done
module it2_rule_engine
    import it2_inf_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int N_A     = 3,
    parameter int N_B     = 3,
    parameter int N_OUT   = 3,
    parameter int N_RULES = N_A * N_B,
    parameter int CW      = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int AW     = (N_RULES > 1) ? $clog2(N_RULES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [N_A*W-1:0]   fou_a_up,
    input  logic [N_A*W-1:0]   fou_a_low,
    input  logic [N_B*W-1:0]   fou_b_up,
    input  logic [N_B*W-1:0]   fou_b_low,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [CW:0]        cfg_data,
    output logic               busy,
    output logic               done,
    output logic [N_OUT*W-1:0] out_up,
    output logic [N_OUT*W-1:0] out_low
);

    state_t        state_q, state_d;
    logic [AW-1:0] rule_q;
    logic          mode_q;
    logic          done_q;

    logic [W-1:0]  a_up_q  [N_A];
    logic [W-1:0]  a_low_q [N_A];
    logic [W-1:0]  b_up_q  [N_B];
    logic [W-1:0]  b_low_q [N_B];

    logic          tbl_en  [N_RULES];
    logic [CW-1:0] tbl_k   [N_RULES];

    logic [W-1:0]  acc_up  [N_OUT];
    logic [W-1:0]  acc_low [N_OUT];

    logic [W-1:0]  sel_a_up, sel_a_low, sel_b_up, sel_b_low;
    logic          sel_en;
    logic [CW-1:0] sel_k;
    logic [W-1:0]  g_up, g_low;

    logic          last_rule;
    logic          cfg_ok;

    assign last_rule = (rule_q == AW'(N_RULES - 1));
    assign cfg_ok    = cfg_we && (int'(cfg_addr) < N_RULES);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (last_rule) state_d = FINISH;
            FINISH:                 state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand and table-entry mux for the rule currently addressed.
    always_comb begin
        sel_a_up  = '0;
        sel_a_low = '0;
        sel_b_up  = '0;
        sel_b_low = '0;
        sel_en    = 1'b0;
        sel_k     = '0;
        for (int r = 0; r < N_RULES; r++) begin
            if (int'(rule_q) == r) begin
                sel_a_up  = a_up_q[rule_a_idx(r, N_B)];
                sel_a_low = a_low_q[rule_a_idx(r, N_B)];
                sel_b_up  = b_up_q[rule_b_idx(r, N_B)];
                sel_b_low = b_low_q[rule_b_idx(r, N_B)];
                sel_en    = tbl_en[r];
                sel_k     = tbl_k[r];
            end
        end
    end

    it2_tnorm #(.W(W)) u_tnorm_up (
        .mode (mode_q),
        .a    (sel_a_up),
        .b    (sel_b_up),
        .y    (g_up)
    );

    it2_tnorm #(.W(W)) u_tnorm_low (
        .mode (mode_q),
        .a    (sel_a_low),
        .b    (sel_b_low),
        .y    (g_low)
    );

    // Datapath: rule table, operand latches, accumulators, outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rule_q  <= '0;
            mode_q  <= TNORM_MIN;
            done_q  <= 1'b0;
            out_up  <= '0;
            out_low <= '0;
            for (int i = 0; i < N_A; i++) begin
                a_up_q[i]  <= '0;
                a_low_q[i] <= '0;
            end
            for (int j = 0; j < N_B; j++) begin
                b_up_q[j]  <= '0;
                b_low_q[j] <= '0;
            end
            for (int r = 0; r < N_RULES; r++) begin
                tbl_en[r] <= 1'b0;
                tbl_k[r]  <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                acc_up[k]  <= '0;
                acc_low[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The table write lands on the same edge as the start
                    // latch, and rule 0 is not read until the next cycle, so
                    // a simultaneous write is already visible to the run.
                    if (cfg_ok) begin
                        for (int r = 0; r < N_RULES; r++) begin
                            if (int'(cfg_addr) == r) begin
                                tbl_en[r] <= cfg_data[CW];
                                tbl_k[r]  <= cfg_data[CW-1:0];
                            end
                        end
                    end
                    if (start) begin
                        mode_q <= mode;
                        rule_q <= '0;
                        // Lower grades are clamped to their upper grade here,
                        // so both t-norm paths stay ordered and out_low can
                        // never exceed out_up.
                        for (int i = 0; i < N_A; i++) begin
                            a_up_q[i]  <= fou_a_up[i*W +: W];
                            a_low_q[i] <= (fou_a_low[i*W +: W] > fou_a_up[i*W +: W]) ?
                                          fou_a_up[i*W +: W] : fou_a_low[i*W +: W];
                        end
                        for (int j = 0; j < N_B; j++) begin
                            b_up_q[j]  <= fou_b_up[j*W +: W];
                            b_low_q[j] <= (fou_b_low[j*W +: W] > fou_b_up[j*W +: W]) ?
                                          fou_b_up[j*W +: W] : fou_b_low[j*W +: W];
                        end
                        for (int k = 0; k < N_OUT; k++) begin
                            acc_up[k]  <= '0;
                            acc_low[k] <= '0;
                        end
                    end
                end
                RUN: begin
                    if (sel_en) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (int'(sel_k) == k) begin
                                if (g_up > acc_up[k])   acc_up[k]  <= g_up;
                                if (g_low > acc_low[k]) acc_low[k] <= g_low;
                            end
                        end
                    end
                    rule_q <= rule_q + 1'b1;
                end
                FINISH: begin
                    for (int k = 0; k < N_OUT; k++) begin
                        out_up[k*W +: W]  <= acc_up[k];
                        out_low[k*W +: W] <= acc_low[k];
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_it2_rule_engine.sv
module tb_it2_rule_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [23:0] fou_a_up, fou_a_low, fou_b_up, fou_b_low;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [2:0]  cfg_data;
    logic        busy;
    logic        done;
    logic [23:0] out_up, out_low;

    int n_tests = 0;
    int n_fail  = 0;

    it2_rule_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .fou_a_up  (fou_a_up),
        .fou_a_low (fou_a_low),
        .fou_b_up  (fou_b_up),
        .fou_b_low (fou_b_low),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .done      (done),
        .out_up    (out_up),
        .out_low   (out_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input logic [3:0] a, input logic [2:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Issues start (optionally with a same-cycle table write) and watches
    // 20 cycles. Cycle n is the state after the n-th edge following the start edge.
    task automatic run_eval(input logic m, input logic wr, input logic [3:0] wa,
                            input logic [2:0] wd, output int first_done,
                            output int n_done, output int n_busy);
        first_done = -1; n_done = 0; n_busy = 0;
        @(negedge clk);
        mode = m; start = 1'b1;
        if (wr) begin cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        if (busy) n_busy++;
        if (done) n_done++;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = n;
            end
        end
    endtask

    task automatic test_reset();
        int fd, nd, nb;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
        end
        n_tests++;
        if ({out_up, out_low} !== 48'h0) begin
            n_fail++; $display("FAIL reset_outs: up=%h low=%h required 0", out_up, out_low);
        end
        @(negedge clk);
        rst = 1'b1;
        fou_a_up = {3{8'd200}}; fou_b_up = {3{8'd200}};
        fou_a_low = {3{8'd100}}; fou_b_low = {3{8'd100}};
        run_eval(1'b0, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (fd !== 10 || nd !== 1) begin
            n_fail++; $display("FAIL reset_run_done: cycle=%0d pulses=%0d required 10/1", fd, nd);
        end
        n_tests++;
        if ({out_up, out_low} !== 48'h0) begin
            n_fail++; $display("FAIL reset_run_outs: up=%h low=%h required 0 (all rules off)", out_up, out_low);
        end
    endtask

    task automatic test_min_agg();
        int fd, nd, nb;
        for (int r = 0; r < 9; r++) cfg_write(4'(r), 3'b100);
        fou_a_up  = {3{8'd255}};
        fou_b_up  = {8'd0, 8'd0, 8'd128};
        fou_a_low = {3{8'd64}};
        fou_b_low = {3{8'd64}};
        run_eval(1'b0, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (fd !== 10 || nd !== 1) begin
            n_fail++; $display("FAIL min_done: cycle=%0d pulses=%0d required 10/1", fd, nd);
        end
        n_tests++;
        if (nb !== 10) begin
            n_fail++; $display("FAIL min_busy_len: got %0d required 10", nb);
        end
        n_tests++;
        if (out_up !== 24'h000080) begin
            n_fail++; $display("FAIL min_up: got %h required 000080", out_up);
        end
        n_tests++;
        if (out_low !== 24'h000040) begin
            n_fail++; $display("FAIL min_low: got %h required 000040", out_low);
        end
    endtask

    task automatic test_product();
        int fd, nd, nb;
        for (int r = 1; r < 9; r++) cfg_write(4'(r), 3'b000);
        cfg_write(4'd0, 3'b110);
        fou_a_up  = {8'd0, 8'd0, 8'd255};
        fou_b_up  = {8'd0, 8'd0, 8'd255};
        fou_a_low = {8'd0, 8'd0, 8'd128};
        fou_b_low = {8'd0, 8'd0, 8'd128};
        run_eval(1'b1, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (fd !== 10) begin
            n_fail++; $display("FAIL prod_done: cycle=%0d required 10", fd);
        end
        n_tests++;
        if (out_up !== 24'hFE0000) begin
            n_fail++; $display("FAIL prod_up: got %h required fe0000", out_up);
        end
        n_tests++;
        if (out_low !== 24'h400000) begin
            n_fail++; $display("FAIL prod_low: got %h required 400000", out_low);
        end
    endtask

    task automatic test_clamp();
        int fd, nd, nb;
        cfg_write(4'd0, 3'b101);
        fou_a_up  = {8'd0, 8'd0, 8'd100};
        fou_a_low = {8'd0, 8'd0, 8'd200};
        fou_b_up  = {3{8'd255}};
        fou_b_low = {3{8'd255}};
        run_eval(1'b0, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (out_up !== 24'h006400 || out_low !== 24'h006400) begin
            n_fail++; $display("FAIL clamp: up=%h low=%h required 006400/006400", out_up, out_low);
        end
        // Out-of-range addresses must not touch the table.
        cfg_write(4'd9, 3'b100);
        cfg_write(4'd15, 3'b100);
        run_eval(1'b0, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (out_up !== 24'h006400 || out_low !== 24'h006400) begin
            n_fail++; $display("FAIL addr_range: up=%h low=%h required 006400/006400", out_up, out_low);
        end
    endtask

    task automatic test_write_with_start();
        int fd, nd, nb;
        run_eval(1'b0, 1'b1, 4'd0, 3'b100, fd, nd, nb);
        n_tests++;
        if (fd !== 10 || out_up !== 24'h000064 || out_low !== 24'h000064) begin
            n_fail++;
            $display("FAIL write_start: cycle=%0d up=%h low=%h required 10 000064/000064", fd, out_up, out_low);
        end
    endtask

    task automatic test_busy_guards();
        int fd, nd, nb;
        fd = -1; nd = 0;
        fou_a_up  = {8'd0, 8'd0, 8'd128};
        fou_b_up  = {8'd0, 8'd0, 8'd255};
        fou_a_low = {3{8'd64}};
        fou_b_low = {3{8'd64}};
        @(negedge clk);
        mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                nd++;
                if (fd < 0) fd = n;
            end
            if (n == 3) begin
                start = 1'b1;
                fou_a_up = {8'd0, 8'd0, 8'd10};
            end
            if (n == 4) begin
                start = 1'b0;
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 3'b000;
            end
            if (n == 5) cfg_we = 1'b0;
        end
        n_tests++;
        if (fd !== 10 || nd !== 1) begin
            n_fail++; $display("FAIL guard_done: cycle=%0d pulses=%0d required 10/1", fd, nd);
        end
        n_tests++;
        if (out_up !== 24'h000080 || out_low !== 24'h000040) begin
            n_fail++; $display("FAIL guard_result: up=%h low=%h required 000080/000040", out_up, out_low);
        end
        run_eval(1'b0, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (out_up !== 24'h00000A || out_low !== 24'h00000A) begin
            n_fail++; $display("FAIL guard_table_kept: up=%h low=%h required 00000a/00000a", out_up, out_low);
        end
    endtask

    task automatic test_reset_midrun();
        int fd, nd, nb;
        fou_a_up = {8'd0, 8'd0, 8'd128};
        run_eval(1'b0, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (out_up !== 24'h000080) begin
            n_fail++; $display("FAIL abort_pre: up=%h required 000080", out_up);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, done} !== 2'b00 || {out_up, out_low} !== 48'h0) begin
            n_fail++;
            $display("FAIL abort_state: busy/done=%b up=%h low=%h required 00 0 0", {busy, done}, out_up, out_low);
        end
        @(negedge clk);
        rst = 1'b1;
        nd = 0; nb = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        n_tests++;
        if (nd !== 0 || nb !== 0) begin
            n_fail++; $display("FAIL abort_quiet: done pulses=%0d busy cycles=%0d required 0/0", nd, nb);
        end
        run_eval(1'b0, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (fd !== 10 || out_up !== 24'h0 || out_low !== 24'h0) begin
            n_fail++; $display("FAIL abort_tbl_cleared: cycle=%0d up=%h low=%h required 10 0/0", fd, out_up, out_low);
        end
        cfg_write(4'd0, 3'b100);
        run_eval(1'b0, 1'b0, 4'd0, 3'd0, fd, nd, nb);
        n_tests++;
        if (fd !== 10 || nd !== 1 || out_up !== 24'h000080 || out_low !== 24'h000040) begin
            n_fail++;
            $display("FAIL abort_recover: cycle=%0d pulses=%0d up=%h low=%h required 10/1 000080/000040",
                     fd, nd, out_up, out_low);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode = 1'b0;
        fou_a_up = '0; fou_a_low = '0; fou_b_up = '0; fou_b_low = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_min_agg();
        test_product();
        test_clamp();
        test_write_with_start();
        test_busy_guards();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
